hier_rr_node: RTL and testbench

Parametrised hierarchy node that gathers `N_CHILD` child channels onto one output stream. Each channel uses a valid/ready handshake. A round-robin arbiter picks one channel per cycle and a single output register holds the result. This block replaces fixed-fan-out hierarchy nodes with one configurable node: child count and data width are parameters, and flow control is real. It sits between leaf producers and the next hierarchy level.

---
 rtl/hier_node_pkg.sv | 24 ++
 rtl/hier_rr_arb.sv | 35 +++
 rtl/hier_rr_node.sv | 104 ++++++++++
 tb/tb_hier_rr_node.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hier_node_pkg.sv
// hier_node_pkg: shared constants, types and helpers for the hierarchy node.
// No ports; imported by hier_rr_arb, hier_rr_node and the bench.
package hier_node_pkg;

    localparam int HIER_N_CHILD_DEF = 5;
    localparam int HIER_DATA_W_DEF  = 8;

    // Output register occupancy, named for readability in benches.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hier_state_e;

    // Index width for n channels; never below 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hier_rr_arb.sv
// hier_rr_arb: combinational round-robin pick starting after ptr.
// Ports: req (per-channel request), ptr (last winner), en (grant enable),
//        gnt (one-hot, zero when en=0), gnt_id (encoded winner).
module hier_rr_arb
    import hier_node_pkg::*;
#(
    parameter  int N    = HIER_N_CHILD_DEF,
    localparam int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic w_found;

    // Walk ptr+1 .. ptr+N (mod N); the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && req[(int'(ptr) + k) % N]) begin
                w_found = 1'b1;
                gnt_id  = ID_W'((int'(ptr) + k) % N);
            end
        end
        if (en && w_found) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/hier_rr_node.sv
// hier_rr_node: N_CHILD valid/ready channels merged round-robin into one
// registered output stream (out_valid/out_data/out_id, out_ready).
// Ports: clk, rst_n (async, active-low), in_valid/in_data/in_ready per
// channel, out_* stream, busy. With HIER_RR_NODE_STATS_EN defined, also
// stat_clr and grant_cnt (saturating per-channel transfer counters).
module hier_rr_node
    import hier_node_pkg::*;
#(
    parameter  int N_CHILD = HIER_N_CHILD_DEF,
    parameter  int DATA_W  = HIER_DATA_W_DEF,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = clog2(N_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CHILD-1:0]          in_valid,
    input  logic [N_CHILD*DATA_W-1:0]   in_data,
    output logic [N_CHILD-1:0]          in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [ID_W-1:0]             out_id,
    input  logic                        out_ready,
    output logic                        busy
`ifdef HIER_RR_NODE_STATS_EN
    ,
    input  logic                        stat_clr,
    output logic [N_CHILD*CNT_W-1:0]    grant_cnt
`endif
);

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [ID_W-1:0]     r_out_id;
    logic [ID_W-1:0]     r_ptr;

    logic                w_load;
    logic                w_en;
    logic                w_take;
    logic [N_CHILD-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_id;

    assign w_load = !r_out_valid || out_ready;
    // rst_n gates the grant so no producer sees ready while in reset.
    assign w_en   = w_load && rst_n;
    assign w_take = |w_gnt;

    hier_rr_arb #(
        .N      (N_CHILD)
    ) u_arb (
        .req    (in_valid),
        .ptr    (r_ptr),
        .en     (w_en),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_ptr       <= ID_W'(N_CHILD - 1);
        end else if (w_load) begin
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_gnt_id*DATA_W +: DATA_W];
                r_out_id    <= w_gnt_id;
                r_ptr       <= w_gnt_id;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_gnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign busy      = (|in_valid) || r_out_valid;

`ifdef HIER_RR_NODE_STATS_EN
    for (genvar i = 0; i < N_CHILD; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        // Clear beats a coincident grant; counting stops at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (stat_clr) begin
                r_cnt <= '0;
            end else if (w_gnt[i] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign grant_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
`else
    // CNT_W only sizes the stats counters, absent in this build.
    if (CNT_W < 1) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_hier_rr_node.sv
// tb_hier_rr_node: directed and random checks of hier_rr_node against
// a transaction-level model of the round-robin node.
module tb_hier_rr_node;
    import hier_node_pkg::*;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_ready;
    logic            busy;
    logic            stat_clr;
`ifdef HIER_RR_NODE_STATS_EN
    logic [N*CW-1:0] grant_cnt;
    logic [N*2-1:0]  grant_cnt2;
    logic [N-1:0]    d_in_ready;
    logic            d_out_valid;
    logic [DW-1:0]   d_out_data;
    logic [IW-1:0]   d_out_id;
    logic            d_busy;
`endif

    int vectors = 0;
    int errors  = 0;

    hier_state_e   m_state;
    logic [DW-1:0] m_data;
    int            m_id;
    int            m_last;
    int            m_cnt  [N];
    int            m_cnt2 [N];

    always #5 clk = ~clk;

    hier_rr_node #(
        .N_CHILD   (N),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef HIER_RR_NODE_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .grant_cnt (grant_cnt)
`endif
    );

`ifdef HIER_RR_NODE_STATS_EN
    hier_rr_node #(
        .N_CHILD   (N),
        .DATA_W    (DW),
        .CNT_W     (2)
    ) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (d_in_ready),
        .out_valid (d_out_valid),
        .out_data  (d_out_data),
        .out_id    (d_out_id),
        .out_ready (out_ready),
        .busy      (d_busy),
        .stat_clr  (stat_clr),
        .grant_cnt (grant_cnt2)
    );
`endif

    // Winner for the current inputs, or -1 when nothing is granted.
    function automatic int m_pick();
        if (m_state == FULL && !out_ready) return -1;
        for (int k = 1; k <= N; k++) begin
            if (in_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        int g;
        g = m_pick();
        return (g < 0) ? '0 : (N'(1) << g);
    endfunction

    task automatic m_reset();
        m_state = EMPTY;
        m_data  = '0;
        m_id    = 0;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_cnt2[i] = 0;
        end
    endtask

    // Advance one clock edge, updating the model with the same inputs.
    task automatic tick();
        int g;
        g = m_pick();
        @(posedge clk);
        if (g >= 0) begin
            m_state = FULL;
            m_data  = in_data[g*DW +: DW];
            m_id    = g;
            m_last  = g;
        end else if (m_state == EMPTY || out_ready) begin
            m_state = EMPTY;
        end
        for (int i = 0; i < N; i++) begin
            if (stat_clr) begin
                m_cnt[i]  = 0;
                m_cnt2[i] = 0;
            end else if (g == i) begin
                if (m_cnt[i] < 65535) m_cnt[i]++;
                if (m_cnt2[i] < 3) m_cnt2[i]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        stat_clr  = 1'b0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        stat_clr  = 1'b0;
        rand_data();
        in_valid  = N'($urandom) | N'(1);
        out_ready = 1'b1;
        m_reset();
        #2;
        vectors++;
        if (in_ready !== '0)
            $display("FAIL reset_ready: got %b expected 0", in_ready);
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_data, out_id} !== '0)
            $display("FAIL reset_regs: got v=%b d=%h id=%0d expected 0",
                     out_valid, out_data, out_id);
        in_valid = '0;
        rst_n    = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || in_ready !== '0 || out_valid !== 1'b0)
            $display("FAIL reset_idle: got busy=%b rdy=%b v=%b expected 0",
                     busy, in_ready, out_valid);
`ifdef HIER_RR_NODE_STATS_EN
        vectors++;
        if (grant_cnt !== '0)
            $display("FAIL reset_cnt: got %h expected 0", grant_cnt);
`endif
        if (in_ready !== '0 || busy !== 1'b0) errors++;
        if (out_valid !== 1'b0) errors++;
    endtask

    task automatic test_single();
        rand_data();
        in_data[3*DW +: DW] = 8'hA5;
        in_valid  = N'(8);
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 5'b01000 || in_ready !== exp_rdy()) begin
            errors++;
            $display("FAIL single_ready: got %b expected 01000", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_id !== 3'd3) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h id=%0d expected 1 a5 3",
                     out_valid, out_data, out_id);
        end
        in_valid = '0;
        #1;
        vectors++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL single_ready_drop: got %b expected 0", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        int seq [7];
        seq = '{0, 1, 2, 3, 4, 0, 1};
        do_reset();
        rand_data();
        in_valid  = '1;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            vectors++;
            if (in_ready !== exp_rdy()) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b expected %b",
                         c, in_ready, exp_rdy());
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || int'(out_id) != seq[c] ||
                out_data !== m_data) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b id=%0d d=%h expected 1 %0d %h",
                         c, out_valid, out_id, out_data, seq[c], m_data);
            end
            in_data[m_id*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] hold;
        int            nxt;
        hold      = m_data;
        nxt       = (m_id + 1) % N;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if (in_ready !== '0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b expected 0", c, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== hold) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h expected 1 %h",
                         c, out_valid, out_data, hold);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== (N'(1) << nxt)) begin
            errors++;
            $display("FAIL bp_resume: got %b expected ch %0d", in_ready, nxt);
        end
        tick();
        vectors++;
        if (int'(out_id) != nxt || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_next: got id=%0d v=%b expected %0d 1",
                     out_id, out_valid, nxt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rand_data();
        in_valid  = N'(4);
        out_ready = 1'b0;
        #1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 3'd2) begin
            errors++;
            $display("FAIL mid_fill: got v=%b id=%0d expected 1 2",
                     out_valid, out_id);
        end
        #3;
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            errors++;
            $display("FAIL mid_drop: got v=%b rdy=%b expected 0 0",
                     out_valid, in_ready);
        end
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== N'(1)) begin
            errors++;
            $display("FAIL mid_restart_rdy: got %b expected 00001", in_ready);
        end
        tick();
        vectors++;
        if (out_id !== 3'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: got id=%0d v=%b expected 0 1",
                     out_id, out_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_data();
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            stat_clr  = ($urandom_range(0, 15) == 0);
            #1;
            vectors++;
            if (in_ready !== exp_rdy() ||
                busy !== ((|in_valid) || (m_state == FULL))) begin
                errors++;
                $display("FAIL rnd_comb[%0d]: got rdy=%b busy=%b expected %b",
                         c, in_ready, busy, exp_rdy());
            end
            tick();
            vectors++;
            if (out_valid !== (m_state == FULL) || out_data !== m_data ||
                int'(out_id) != m_id) begin
                errors++;
                $display("FAIL rnd_out[%0d]: got v=%b d=%h id=%0d expected %b %h %0d",
                         c, out_valid, out_data, out_id, m_state == FULL,
                         m_data, m_id);
            end
`ifdef HIER_RR_NODE_STATS_EN
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (grant_cnt[i*CW +: CW] !== CW'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL rnd_cnt[%0d][%0d]: got %0d expected %0d",
                             c, i, grant_cnt[i*CW +: CW], m_cnt[i]);
                end
            end
`endif
        end
        stat_clr = 1'b0;
    endtask

`ifdef HIER_RR_NODE_STATS_EN
    task automatic test_stats();
        do_reset();
        rand_data();
        in_valid  = N'(2);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tick();
        end
        vectors++;
        if (grant_cnt[CW +: CW] !== CW'(3) || m_cnt[1] != 3) begin
            errors++;
            $display("FAIL stat_count: got %0d expected 3", grant_cnt[CW +: CW]);
        end
        stat_clr = 1'b1;
        #1;
        vectors++;
        if (in_ready !== N'(2)) begin
            errors++;
            $display("FAIL stat_clr_gnt: got %b expected 00010", in_ready);
        end
        tick();
        stat_clr = 1'b0;
        vectors++;
        if (grant_cnt[CW +: CW] !== '0) begin
            errors++;
            $display("FAIL stat_clr: got %0d expected 0", grant_cnt[CW +: CW]);
        end
        do_reset();
        in_valid  = N'(1);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            tick();
        end
        vectors++;
        if (grant_cnt2[1:0] !== 2'd3 || m_cnt2[0] != 3) begin
            errors++;
            $display("FAIL stat_sat: got %0d expected 3", grant_cnt2[1:0]);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef HIER_RR_NODE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
